// File: rtl/window_scan_sweeper.sv
// window_scan_sweeper: raster (x, y) address stream over a runtime-configured, subsampled image window
module window_scan_sweeper #(
  parameter int IMG_WIDTH = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int MAX_SWEEP_X = 24,
  parameter int MAX_SWEEP_Y = 24,
  localparam int W_X = $clog2(IMG_WIDTH),
  localparam int W_Y = $clog2(IMG_HEIGHT),
  localparam int W_SX = $clog2(MAX_SWEEP_X + 1),
  localparam int W_SY = $clog2(MAX_SWEEP_Y + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [W_X-1:0]  cfg_x_start,
  input  logic [W_Y-1:0]  cfg_y_start,
  input  logic [W_SX-1:0] cfg_width,
  input  logic [W_SY-1:0] cfg_height,
  input  logic [W_SX-1:0] cfg_step_x,
  input  logic [W_SY-1:0] cfg_step_y,
  output logic            cfg_err,
  output logic            addr_valid,
  input  logic            addr_ready,
  output logic [W_X-1:0]  x,
  output logic [W_Y-1:0]  y,
  output logic            addr_last_row,
  output logic            addr_last,
  output logic            busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [W_X-1:0] xs, bxs;
  logic [W_Y-1:0] ys, bys;
  logic [W_SX-1:0] w, sx, bw, bsx;
  logic [W_SY-1:0] h, sy, bh, bsy;
  logic [W_SX:0] xo, nxo;
  logic [W_SY:0] yo, nyo;
  logic hs, cfg_hs, ok, load, advance, lr, lst;
  assign busy = state == RUN;
  // handshakes, descriptor check and the next beat (from a fresh descriptor or the current walk)
  always_comb begin
    hs = addr_valid & addr_ready;
    cfg_ready = (state == IDLE) | ((state == RUN) & hs & addr_last);
    cfg_hs = cfg_valid & cfg_ready;
    ok = (cfg_width != '0) & (cfg_height != '0) & (cfg_step_x != '0) & (cfg_step_y != '0)
       & (32'(cfg_width) <= MAX_SWEEP_X) & (32'(cfg_height) <= MAX_SWEEP_Y)
       & (32'(cfg_x_start) + 32'(cfg_width) <= IMG_WIDTH)
       & (32'(cfg_y_start) + 32'(cfg_height) <= IMG_HEIGHT);
    load = cfg_hs & ok;
    advance = load | (hs & ~addr_last);
    bxs = load ? cfg_x_start : xs;
    bys = load ? cfg_y_start : ys;
    bw = load ? cfg_width : w;
    bh = load ? cfg_height : h;
    bsx = load ? cfg_step_x : sx;
    bsy = load ? cfg_step_y : sy;
    nxo = (load | addr_last_row) ? '0 : xo + (W_SX+1)'(sx);
    nyo = load ? '0 : addr_last_row ? yo + (W_SY+1)'(sy) : yo;
    lr = 32'(nxo) + 32'(bsx) >= 32'(bw);
    lst = lr & (32'(nyo) + 32'(bsy) >= 32'(bh));
  end
  // IDLE/RUN control with registered beat outputs; a stalled beat holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_valid <= 1'b0;
      cfg_err <= 1'b0;
      x <= '0;
      y <= '0;
      addr_last_row <= 1'b0;
      addr_last <= 1'b0;
      xo <= '0;
      yo <= '0;
      xs <= '0;
      ys <= '0;
      w <= '0;
      h <= '0;
      sx <= '0;
      sy <= '0;
    end else begin
      cfg_err <= cfg_hs & ~ok;
      if (load) begin
        state <= RUN;
        addr_valid <= 1'b1;
        xs <= cfg_x_start;
        ys <= cfg_y_start;
        w <= cfg_width;
        h <= cfg_height;
        sx <= cfg_step_x;
        sy <= cfg_step_y;
      end else if (hs & addr_last) begin
        state <= IDLE;
        addr_valid <= 1'b0;
      end
      if (advance) begin
        xo <= nxo;
        yo <= nyo;
        x <= W_X'(32'(bxs) + 32'(nxo));
        y <= W_Y'(32'(bys) + 32'(nyo));
        addr_last_row <= lr;
        addr_last <= lst;
      end
    end
  end
endmodule

// File: doc/window_scan_sweeper.md
Name: window_scan_sweeper

Overview:
- Runtime-configurable successor to the fixed-size window address sweeper.
- Accepts a window descriptor: origin, width, height and per-axis subsampling step.
- Emits the (x, y) pixel address stream over that window in raster order on a valid/ready interface, with row-last and window-last flags.
- Sits between the detector scan controller and the integral-image read port; supports zero-bubble back-to-back windows and rejects out-of-bounds descriptors.

Parameters:
- IMG_WIDTH, 41: image width in pixels.
- IMG_HEIGHT, 50: image height in pixels.
- MAX_SWEEP_X, 24: maximum window width.
- MAX_SWEEP_Y, 24: maximum window height.
- W_X (local), $clog2(IMG_WIDTH): x address width.
- W_Y (local), $clog2(IMG_HEIGHT): y address width.
- W_SX (local), $clog2(MAX_SWEEP_X+1): window-x field width.
- W_SY (local), $clog2(MAX_SWEEP_Y+1): window-y field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready.
- cfg_x_start  in  W_X  window origin x.
- cfg_y_start  in  W_Y  window origin y.
- cfg_width  in  W_SX  window width.
- cfg_height  in  W_SY  window height.
- cfg_step_x  in  W_SX  x subsampling step.
- cfg_step_y  in  W_SY  y subsampling step.
- cfg_err  out  1  one-cycle pulse: descriptor rejected.
- addr_valid  out  1  address beat valid.
- addr_ready  in  1  downstream ready.
- x  out  W_X  pixel x address.
- y  out  W_Y  pixel y address.
- addr_last_row  out  1  beat is the last of its row.
- addr_last  out  1  beat is the last of the window.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (rst=1 at posedge; takes priority over every other event):
  - state=IDLE; addr_valid=0, cfg_err=0, busy=0, x=0, y=0, addr_last_row=0, addr_last=0.
  - Reset during RUN abandons the window; addr_valid=0 the following cycle.
- States: IDLE and RUN.
- cfg_ready is combinational: (state==IDLE) | (state==RUN & addr_valid & addr_last & addr_ready).
  - This is a documented combinational path from addr_ready to cfg_ready.
- Descriptor validity (checked on cfg handshake, with widened arithmetic so there is no overflow). All of the following must hold:
  - width>=1, height>=1, step_x>=1, step_y>=1.
  - width<=MAX_SWEEP_X, height<=MAX_SWEEP_Y.
  - x_start+width<=IMG_WIDTH, y_start+height<=IMG_HEIGHT.
- Invalid descriptor:
  - Descriptor is discarded; cfg_err=1 for exactly the next cycle.
  - State becomes or stays IDLE; no address beat is emitted.
- Valid descriptor:
  - Fields are latched; next cycle state=RUN, addr_valid=1, x=x_start, y=y_start.
  - Latency from cfg handshake to first beat: 1 cycle.
- Internal offsets: xo (W_SX+1 bits) and yo (W_SY+1 bits).
  - x = x_start+xo and y = y_start+yo, both registered.
  - Bounds validation guarantees x and y fit in W_X and W_Y.
- Beat flags:
  - addr_last_row = (xo+step_x >= width).
  - addr_last = addr_last_row & (yo+step_y >= height).
  - Both are registered alongside x and y.
- Stall: while addr_valid & !addr_ready, x, y and both flags hold stable.
- On an address handshake that is not last:
  - If not addr_last_row: xo += step_x.
  - Otherwise: xo=0, yo += step_y.
- On the last-beat handshake:
  - With a simultaneous cfg handshake: process the new descriptor as above. If valid, the first beat of the new window appears the next cycle (zero bubble). If invalid, go to IDLE with a cfg_err pulse.
  - Otherwise: go to IDLE with addr_valid=0 the next cycle.
- Beat count per window = ceil(width/step_x) * ceil(height/step_y).
- addr_valid never drops in RUN before the last beat is taken.

Test Plan:
- Raster order: after reset, cfg (5,7,w=3,h=2,step 1,1) with addr_ready=1 -> 6 beats (5,7),(6,7),(7,7),(5,8),(6,8),(7,8); addr_last_row on beats 3 and 6; addr_last on beat 6 only; first beat 1 cycle after cfg handshake.
- Subsampling: cfg (0,0,w=5,h=5,step 2,2) -> 9 beats, x∈{0,2,4}, y∈{0,2,4}; last beat (4,4).
- Bounds checks:
  - cfg x_start=17, w=24 (sum=41) -> accepted.
  - x_start=18, w=24 -> cfg_err pulses one cycle, no beats.
  - w=0 -> cfg_err.
  - step_y=0 -> cfg_err.
  - w=25 -> cfg_err.
- Backpressure: toggle addr_ready with pattern 1,0,0,1 -> outputs stable during stalls; beat sequence identical to the unstalled run.
- Back-to-back: hold cfg_valid with a second descriptor during the last beat -> cfg_ready rises with addr_ready; the next cycle carries the new window's first beat with no gap.
- Reset mid-run: assert rst at beat 3 of a 6-beat window -> next cycle addr_valid=0, busy=0, cfg_ready=1; a new cfg restarts at its origin.
